// File: rtl/pipeline_pkg.sv
// pipeline_pkg: encodings and FSM state type shared by the pipeline hazard logic
package pipeline_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        FP_IDLE = 2'b00,
        FP_BUSY = 2'b01,
        FP_LAST = 2'b10
    } fp_state_t;

endpackage

// File: rtl/fp_occupancy_fsm.sv
// fp_occupancy_fsm: holds Execute while a multi-cycle FP op occupies it
module fp_occupancy_fsm
    import pipeline_pkg::*;
#(
    parameter int FP_LAT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_is_fp,
    output logic o_fp_stall
);

    localparam logic [3:0] LAT_LOAD = (FP_LAT >= 3) ? 4'(FP_LAT - 2) : 4'd0;

    fp_state_t  r_state;
    fp_state_t  w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    // state and remaining-cycle counter register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= FP_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next state and stall; LAST releases Execute and ignores a lingering IsFpE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_fp_stall  = 1'b0;
        case (r_state)
            FP_IDLE: begin
                if (i_is_fp && FP_LAT >= 3) begin
                    o_fp_stall  = 1'b1;
                    w_cnt_nxt   = LAT_LOAD;
                    w_state_nxt = FP_BUSY;
                end else if (i_is_fp && FP_LAT == 2) begin
                    o_fp_stall  = 1'b1;
                    w_state_nxt = FP_LAST;
                end
            end
            FP_BUSY: begin
                o_fp_stall = 1'b1;
                w_cnt_nxt  = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_state_nxt = FP_LAST;
            end
            FP_LAST: w_state_nxt = FP_IDLE;
            default: w_state_nxt = FP_IDLE;
        endcase
        if (!i_rst_n) o_fp_stall = 1'b0;
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use/FP stalls, flushes and perf counters
module hazard_unit_mc
    import pipeline_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int FP_LAT = 4,
    parameter int CNT_W = 32,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  Rs1D,
    input  logic [RA_W-1:0]  Rs2D,
    input  logic [RA_W-1:0]  Rs1E,
    input  logic [RA_W-1:0]  Rs2E,
    input  logic [RA_W-1:0]  RdE,
    input  logic [RA_W-1:0]  RdM,
    input  logic [RA_W-1:0]  RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             IsFpE,
    input  logic             perf_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic             w_lw_stall;
    logic             w_fp_stall;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] rd_m,
        input logic            we_m,
        input logic [RA_W-1:0] rd_w,
        input logic            we_w
    );
        if (rs == '0) return FWD_RF;
        if (we_m && rs == rd_m) return FWD_M;
        if (we_w && rs == rd_w) return FWD_W;
        return FWD_RF;
    endfunction

    fp_occupancy_fsm #(
        .FP_LAT(FP_LAT)
    ) u_fp (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_is_fp   (IsFpE),
        .o_fp_stall(w_fp_stall)
    );

    // forwarding, load-use detection and stall/flush gating; a held Execute is never flushed
    always_comb begin
        ForwardAE  = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE  = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        w_lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
        StallF     = w_lw_stall | w_fp_stall;
        StallD     = StallF;
        StallE     = w_fp_stall;
        FlushM     = w_fp_stall;
        FlushD     = PCSrcE & ~w_fp_stall;
        FlushE     = (w_lw_stall | PCSrcE) & ~w_fp_stall;
    end

    // saturating performance counters, clear beats increment
    always_ff @(posedge clk) begin
        if (!reset || perf_clr) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (StallF && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (FlushD && !(&r_flush_events)) r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: scoreboard bench over FP_LAT=4/1/2 builds and a 4-bit counter build
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, PCSrcE, IsFpE, perf_clr;
    logic [1:0] ResultSrcE;

    logic [3:0]  sf, sd, se, fld, fle, flm;
    logic [1:0]  fa [4];
    logic [1:0]  fb [4];
    logic [31:0] sc0, fe0, sc1, fe1, sc2, fe2;
    logic [3:0]  scc, fec;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.NREGS(32), .FP_LAT(4), .CNT_W(32)) u4 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .IsFpE(IsFpE), .perf_clr(perf_clr),
        .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]), .FlushD(fld[0]), .FlushE(fle[0]),
        .FlushM(flm[0]), .ForwardAE(fa[0]), .ForwardBE(fb[0]),
        .stall_cycles(sc0), .flush_events(fe0));

    hazard_unit_mc #(.NREGS(32), .FP_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .IsFpE(IsFpE), .perf_clr(perf_clr),
        .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]), .FlushD(fld[1]), .FlushE(fle[1]),
        .FlushM(flm[1]), .ForwardAE(fa[1]), .ForwardBE(fb[1]),
        .stall_cycles(sc1), .flush_events(fe1));

    hazard_unit_mc #(.NREGS(32), .FP_LAT(2), .CNT_W(32)) u2 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .IsFpE(IsFpE), .perf_clr(perf_clr),
        .StallF(sf[2]), .StallD(sd[2]), .StallE(se[2]), .FlushD(fld[2]), .FlushE(fle[2]),
        .FlushM(flm[2]), .ForwardAE(fa[2]), .ForwardBE(fb[2]),
        .stall_cycles(sc2), .flush_events(fe2));

    hazard_unit_mc #(.NREGS(32), .FP_LAT(4), .CNT_W(4)) uc (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .IsFpE(IsFpE), .perf_clr(perf_clr),
        .StallF(sf[3]), .StallD(sd[3]), .StallE(se[3]), .FlushD(fld[3]), .FlushE(fle[3]),
        .FlushM(flm[3]), .ForwardAE(fa[3]), .ForwardBE(fb[3]),
        .stall_cycles(scc), .flush_events(fec));

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM} then ForwardAE, ForwardBE
    function automatic logic [31:0] ov(input logic [5:0] s, input logic [1:0] a, input logic [1:0] b);
        return {22'd0, s, a, b};
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return {22'd0, sf[0], sd[0], se[0], fld[0], fle[0], flm[0], fa[0], fb[0]};
            1: return {22'd0, sf[1], sd[1], se[1], fld[1], fle[1], flm[1], fa[1], fb[1]};
            2: return {22'd0, sf[2], sd[2], se[2], fld[2], fle[2], flm[2], fa[2], fb[2]};
            3: return sc0;
            4: return fe0;
            5: return {28'd0, scc};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input int sel, input logic [31:0] e);
        exp_q.push_back('{tag, sel, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0; IsFpE = 0;
    endtask

    // monitor: outputs are presented every cycle, compare whatever this cycle queued
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.tag, a, e.exp);
            end
        end
    end

    initial begin
        reset = 0; perf_clr = 0; idle();
        step(); step();
        chk("rst_vec", 0, 0); chk("rst_sc", 3, 0); chk("rst_fe", 4, 0);

        step(); reset = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        chk("fwd_m_prio", 0, ov(6'b000000, 2'b10, 2'b00));
        step(); RegWriteM = 0; Rs2E = 5;
        chk("fwd_w", 0, ov(6'b000000, 2'b01, 2'b01));
        step(); idle(); RegWriteM = 1; RegWriteW = 1;
        chk("fwd_x0", 0, ov(6'b000000, 2'b00, 2'b00));
        step(); idle(); Rs1E = 9; RdM = 4; RegWriteM = 1; RdW = 9; Rs2E = 4;
        chk("fwd_mixed", 0, ov(6'b000000, 2'b00, 2'b10));

        step(); idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        chk("lw_stall", 0, ov(6'b110010, 2'b00, 2'b00));
        step(); idle(); ResultSrcE = 2'b01;
        chk("lw_rd0", 0, 0); chk("lw_sc", 3, 1);
        step(); idle(); PCSrcE = 1;
        chk("br_idle", 0, ov(6'b000110, 2'b00, 2'b00)); chk("br_sc", 3, 1); chk("br_fe0", 4, 0);
        step(); idle(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
        chk("lw_br", 0, ov(6'b110110, 2'b00, 2'b00)); chk("br_fe1", 4, 1);
        step(); idle();
        chk("quiet", 0, 0); chk("sc2", 3, 2); chk("fe2", 4, 2);

        step(); IsFpE = 1;
        chk("fp4_c0", 0, ov(6'b111001, 2'b00, 2'b00)); chk("fp1_c0", 1, 0);
        chk("fp2_c0", 2, ov(6'b111001, 2'b00, 2'b00));
        step(); PCSrcE = 1;
        chk("fp4_c1_br", 0, ov(6'b111001, 2'b00, 2'b00));
        chk("fp1_c1_br", 1, ov(6'b000110, 2'b00, 2'b00));
        chk("fp2_c1_last", 2, ov(6'b000110, 2'b00, 2'b00));
        step(); PCSrcE = 0;
        chk("fp4_c2", 0, ov(6'b111001, 2'b00, 2'b00)); chk("fp1_c2", 1, 0);
        chk("fp2_c2", 2, ov(6'b111001, 2'b00, 2'b00));
        step();
        chk("fp4_c3_last", 0, 0); chk("fp2_c3_last", 2, 0);
        step();
        chk("fp4_c4_again", 0, ov(6'b111001, 2'b00, 2'b00)); chk("fp1_c4", 1, 0);
        chk("fp2_c4", 2, ov(6'b111001, 2'b00, 2'b00));
        chk("fp_sc5", 3, 5); chk("fp_fe2", 4, 2);
        step();
        chk("fp4_busy1", 0, ov(6'b111001, 2'b00, 2'b00)); chk("fp_sc6", 3, 6);
        step(); reset = 0; IsFpE = 0;
        chk("rst_busy", 0, 0); chk("rst_busy_sc", 3, 7);
        step(); reset = 1;
        chk("post_rst", 0, 0); chk("post_rst_sc", 3, 0); chk("post_rst_fe", 4, 0);

        for (int i = 0; i < 20; i++) begin
            step(); idle(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
            chk("sat_c4", 5, (i > 15) ? 32'd15 : 32'(i));
            chk("sat_c32", 3, 32'(i));
        end
        step(); perf_clr = 1;
        chk("clr_pre_c4", 5, 15); chk("clr_pre_c32", 3, 20);
        step(); idle(); perf_clr = 0;
        chk("clr_c4", 5, 0); chk("clr_c32", 3, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0 pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Multi-cycle-aware hazard and forwarding controller for the five-stage pipelined RISC-V core. It is the parametrised successor to the single-cycle hazard unit and sits beside the controller and datapath. It adds variable-latency floating-point occupancy of Execute through a small FSM, explicit Execute stall and Memory bubble outputs, and saturating stall/flush performance counters. Forwarding, load-use and branch-flush behaviour are retained and generalised in register-address width.

## Interface
- NREGS, 32: architectural registers; RA_W = $clog2(NREGS) (5 at default).
- FP_LAT, 4: cycles an FP op occupies Execute; legal range 1..15.
- CNT_W, 32: performance counter width.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- Rs1D, Rs2D  in  RA_W  Decode source registers.
- Rs1E, Rs2E, RdE  in  RA_W  Execute sources and destination.
- RdM, RdW  in  RA_W  Memory and Writeback destinations.
- RegWriteM, RegWriteW  in  1  register write enables.
- ResultSrcE  in  2  Execute result select; 2'b01 marks a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- IsFpE  in  1  instruction in Execute is an FP op.
- perf_clr  in  1  synchronous clear of both counters.
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers.
- FlushD, FlushE, FlushM  out  1  bubble IF/ID, ID/EX and EX/MEM.
- ForwardAE, ForwardBE  out  2  2'b10 from M, 2'b01 from W, 2'b00 from the register file.
- stall_cycles, flush_events  out  CNT_W  performance counters.

## Operation
- Forwarding (combinational):
  - ForwardAE = 10 when Rs1E==RdM, RegWriteM=1 and Rs1E!=0.
  - Otherwise ForwardAE = 01 when Rs1E==RdW, RegWriteW=1 and Rs1E!=0.
  - Otherwise ForwardAE = 00. ForwardBE is identical using Rs2E.
  - M has priority over W. Register x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==01) & (RdE!=0) & (Rs1D==RdE | Rs2D==RdE).
- FP occupancy FSM, states IDLE / BUSY / LAST, with a 4-bit down-counter cnt:
  - IDLE & IsFpE & FP_LAT>=3: fpStall=1, cnt<=FP_LAT-2, go to BUSY.
  - IDLE & IsFpE & FP_LAT==2: fpStall=1, go to LAST.
  - FP_LAT==1: the FSM stays in IDLE and fpStall stays 0.
  - BUSY: fpStall=1, cnt<=cnt-1; go to LAST when cnt==1.
  - LAST: fpStall=0. The FP op leaves Execute on this edge. Go to IDLE unconditionally; the still-high IsFpE is ignored.
- Output equations:
  - StallF = StallD = lwStall | fpStall.
  - StallE = fpStall.
  - FlushM = fpStall.
  - FlushD = PCSrcE & ~fpStall.
  - FlushE = (lwStall | PCSrcE) & ~fpStall. Execute is never flushed while it is held.
- The FP unit latches its operands in the entry cycle. This block does not guarantee that forwarded values remain valid on later BUSY cycles.
- Counters:
  - stall_cycles += 1 on each cycle with StallF=1.
  - flush_events += 1 on each cycle with FlushD=1.
  - Both counters saturate at all-ones.
  - perf_clr has priority over increment.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and FSM state, in the same cycle.
- An FP op first seen in cycle t holds StallF/StallD/StallE/FlushM high for exactly FP_LAT-1 cycles (t .. t+FP_LAT-2). They drop in cycle t+FP_LAT-1.
- Back-to-back FP ops: the second op is seen in IDLE one cycle after LAST, giving no gap in occupancy accounting.
- Reset (reset=0 at a clk edge): state<=IDLE, cnt<=0, counters<=0.
  - fpStall is 0 in the cycle after reset, even if reset arrives mid-BUSY.
  - While reset is low, FSM-derived outputs are forced 0.
- Simultaneous lwStall and PCSrcE: FlushD=1, FlushE=1, StallF/StallD=1. The flush wins in D because the datapath applies flush over stall.
- Counter at all-ones with an increment condition: holds at all-ones.

## Structure
- Shared package pipeline_pkg holds:
  - ResultSrc encodings (RES_ALU=00, RES_LOAD=01, RES_PC4=10).
  - Forward encodings (FWD_RF, FWD_W, FWD_M).
  - The FP FSM state enum.
- One sub-module, fp_occupancy_fsm: FSM plus cnt, producing fpStall. The top level holds forwarding, load-use, output gating and counters.

## Test plan
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Rs1E=0 with RdM=0 -> ForwardAE=00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0, stall_cycles +1.
- FP_LAT=4, IsFpE held high 4 cycles -> stalls/FlushM high for cycles 0-2, low in cycle 3, FSM back in IDLE in cycle 4. Repeat with FP_LAT=1 -> no stall; FP_LAT=2 -> one stall cycle.
- PCSrcE=1 in IDLE -> FlushD=FlushE=1, flush_events +1. PCSrcE=1 during BUSY -> FlushD=FlushE=0.
- reset=0 in the second BUSY cycle -> next cycle fpStall=0, state IDLE, counters 0.
- Preload a CNT_W=4 build to 4'hF with StallF held -> stays 4'hF. perf_clr=1 -> 0 on the next edge.
